ibex_multdiv_sched: RTL and testbench

//  Sequencer/arbiter for the shared RV32M mul/div datapath of ibex_ex_block (mult_sel=1 or div_sel=1).

---
 rtl/ibex_multdiv_sched.sv | 202 ++++++++++++++++++++
 tb/tb_ibex_multdiv_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_sched.sv
// Round-robin sequencer for the shared RV32M mul/div datapath: grants one requester,
// latches its operands, drives the ex-block handshake and returns the tagged result.
module ibex_multdiv_sched #(
  parameter int NumReq = 2,
  parameter int TagW   = 4,
  localparam int IdW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [2*NumReq-1:0]    req_op_i,
  input  logic [2*NumReq-1:0]    req_signed_i,
  input  logic [32*NumReq-1:0]   req_opa_i,
  input  logic [32*NumReq-1:0]   req_opb_i,
  input  logic [TagW*NumReq-1:0] req_tag_i,
  input  logic                   flush_i,
  output logic                   mult_en_o,
  output logic                   div_en_o,
  output logic                   mult_sel_o,
  output logic                   div_sel_o,
  output logic [1:0]             md_op_o,
  output logic [1:0]             md_signed_o,
  output logic [31:0]            md_opa_o,
  output logic [31:0]            md_opb_o,
  output logic                   md_ready_id_o,
  input  logic                   imd_val_we_i,
  input  logic [33:0]            imd_val_d_i,
  output logic [33:0]            imd_val_q_o,
  input  logic                   ex_valid_i,
  input  logic [31:0]            result_ex_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_result_o,
  output logic [IdW-1:0]         rsp_id_o,
  output logic [TagW-1:0]        rsp_tag_o,
  output logic [7:0]             last_lat_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      signed_q, signed_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic [33:0]     imd_val_q, imd_val_d;
  logic [31:0]     result_q, result_d;
  logic [7:0]      lat_cnt_q, lat_cnt_d;
  logic [7:0]      last_lat_q, last_lat_d;
  logic [7:0]      lat_inc;

  logic            gnt_found;
  logic            gnt_vld;
  logic [IdW-1:0]  gnt_id;
  logic [1:0]      gnt_op;
  logic [1:0]      gnt_signed;
  logic [31:0]     gnt_opa;
  logic [31:0]     gnt_opb;
  logic [TagW-1:0] gnt_tag;

  // First pass searches from the pointer upwards, second pass wraps around to index 0.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_id     = '0;
    gnt_op     = '0;
    gnt_signed = '0;
    gnt_opa    = '0;
    gnt_opb    = '0;
    gnt_tag    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_found && req_valid_i[i] && (i >= int'(rr_ptr_q))) begin
        gnt_found = 1'b1;
        gnt_id    = IdW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_found && req_valid_i[i]) begin
        gnt_found = 1'b1;
        gnt_id    = IdW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_id == IdW'(i)) begin
        gnt_op     = req_op_i[2*i +: 2];
        gnt_signed = req_signed_i[2*i +: 2];
        gnt_opa    = req_opa_i[32*i +: 32];
        gnt_opb    = req_opb_i[32*i +: 32];
        gnt_tag    = req_tag_i[TagW*i +: TagW];
      end
    end
  end

  // Gated by rst_ni so every output reads zero while reset is held.
  assign gnt_vld = (state_q == IDLE) && !flush_i && rst_ni && gnt_found;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = gnt_vld && (gnt_id == IdW'(i));
    end
  end

  assign lat_inc = (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    signed_d   = signed_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    tag_d      = tag_q;
    imd_val_d  = imd_val_q;
    result_d   = result_q;
    lat_cnt_d  = lat_cnt_q;
    last_lat_d = last_lat_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d      = gnt_id;
          op_d      = gnt_op;
          signed_d  = gnt_signed;
          opa_d     = gnt_opa;
          opb_d     = gnt_opb;
          tag_d     = gnt_tag;
          rr_ptr_d  = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + 1'b1;
          lat_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        lat_cnt_d = lat_inc;
        if (imd_val_we_i) imd_val_d = imd_val_d_i;
        if (flush_i) begin
          state_d = DRAIN;
        end else if (ex_valid_i) begin
          result_d   = result_ex_i;
          last_lat_d = lat_inc;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (flush_i) state_d = DRAIN;
        else if (rsp_ready_i) state_d = IDLE;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      op_q       <= '0;
      signed_q   <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      tag_q      <= '0;
      imd_val_q  <= '0;
      result_q   <= '0;
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      signed_q   <= signed_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      tag_q      <= tag_d;
      imd_val_q  <= imd_val_d;
      result_q   <= result_d;
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign mult_en_o     = (state_q == BUSY) && !op_q[1];
  assign div_en_o      = (state_q == BUSY) && op_q[1];
  assign mult_sel_o    = mult_en_o;
  assign div_sel_o     = div_en_o;
  assign md_ready_id_o = (state_q == BUSY);
  assign md_op_o       = op_q;
  assign md_signed_o   = signed_q;
  assign md_opa_o      = opa_q;
  assign md_opb_o      = opb_q;
  assign imd_val_q_o   = imd_val_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_result_o  = result_q;
  assign rsp_id_o      = id_q;
  assign rsp_tag_o     = tag_q;
  assign last_lat_o    = last_lat_q;

endmodule

// File: tb/tb_ibex_multdiv_sched.sv
// Randomized bench for ibex_multdiv_sched: a transaction-level scheduler model plus an
// arithmetic RV32M reference standing in for the ex block.
module tb_ibex_multdiv_sched;

  localparam int NumReq = 2;
  localparam int TagW   = 4;

  logic                   clk, rst_n;
  logic [NumReq-1:0]      req_valid_i, req_ready_o;
  logic [2*NumReq-1:0]    req_op_i, req_signed_i;
  logic [32*NumReq-1:0]   req_opa_i, req_opb_i;
  logic [TagW*NumReq-1:0] req_tag_i;
  logic                   flush_i;
  logic                   mult_en_o, div_en_o, mult_sel_o, div_sel_o, md_ready_id_o;
  logic [1:0]             md_op_o, md_signed_o;
  logic [31:0]            md_opa_o, md_opb_o;
  logic                   imd_val_we_i;
  logic [33:0]            imd_val_d_i, imd_val_q_o;
  logic                   ex_valid_i;
  logic [31:0]            result_ex_i;
  logic                   rsp_valid_o, rsp_ready_i;
  logic [31:0]            rsp_result_o;
  logic [0:0]             rsp_id_o;
  logic [TagW-1:0]        rsp_tag_o;
  logic [7:0]             last_lat_o;

  ibex_multdiv_sched #(.NumReq(NumReq), .TagW(TagW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_signed_i(req_signed_i), .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_tag_i(req_tag_i), .flush_i(flush_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
    .md_op_o(md_op_o), .md_signed_o(md_signed_o), .md_opa_o(md_opa_o), .md_opb_o(md_opb_o),
    .md_ready_id_o(md_ready_id_o), .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i),
    .imd_val_q_o(imd_val_q_o), .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_id_o(rsp_id_o), .rsp_tag_o(rsp_tag_o), .last_lat_o(last_lat_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } req_t;

  typedef enum {PH_IDLE, PH_BUSY, PH_RESP, PH_DRAIN} phase_e;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RV32M semantics including the division-by-zero and signed-overflow results.
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, p;
    logic signed [31:0] sa, sb;
    logic [63:0] pv;
    xa = sgn[0] ? longint'($signed(a)) : longint'({32'b0, a});
    xb = sgn[1] ? longint'($signed(b)) : longint'({32'b0, b});
    p  = xa * xb;
    pv = 64'(p);
    sa = a;
    sb = b;
    case (op)
      2'd0: return pv[31:0];
      2'd1: return pv[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sgn[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return 32'(sa / sb);
        end
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sgn[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return 32'(sa % sb);
        end
        return a % b;
      end
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op  = 2'($urandom_range(0, 3));
    r.sgn = r.op[1] ? ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
    r.a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
    case ($urandom_range(0, 7))
      0:       r.b = 32'd0;
      1:       r.b = 32'hFFFF_FFFF;
      default: r.b = 32'($urandom);
    endcase
    r.tag = 4'($urandom_range(0, 15));
    return r;
  endfunction

  req_t   cur[NumReq];
  bit     has_req[NumReq];
  req_t   dq0[$];
  req_t   dq1[$];
  phase_e ph;
  int     m_ptr, m_id, m_cnt, m_wait, m_last;
  req_t   m_req;
  logic [33:0] m_imd;
  logic [31:0] m_res;
  int     wait_override;
  bit     allow_flush;
  int     req_pct;

  task automatic drive_reqs();
    for (int i = 0; i < NumReq; i++) begin
      req_valid_i[i]            = has_req[i];
      req_op_i[2*i +: 2]        = cur[i].op;
      req_signed_i[2*i +: 2]    = cur[i].sgn;
      req_opa_i[32*i +: 32]     = cur[i].a;
      req_opb_i[32*i +: 32]     = cur[i].b;
      req_tag_i[TagW*i +: TagW] = cur[i].tag;
    end
  endtask

  task automatic step();
    int g;
    bit busy;
    logic [1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NumReq; i++) begin
      if (!has_req[i] && $urandom_range(0, 99) < req_pct) begin
        if (i == 0 && dq0.size() > 0) cur[0] = dq0.pop_front();
        else if (i == 1 && dq1.size() > 0) cur[1] = dq1.pop_front();
        else cur[i] = rand_req();
        has_req[i] = 1'b1;
      end
    end
    drive_reqs();
    flush_i      = allow_flush && ($urandom_range(0, 24) == 0);
    rsp_ready_i  = ($urandom_range(0, 3) != 0);
    imd_val_we_i = 1'($urandom_range(0, 1));
    imd_val_d_i  = {2'($urandom_range(0, 3)), 32'($urandom)};
    if (ph == PH_BUSY && m_wait == 0) begin
      ex_valid_i  = 1'b1;
      result_ex_i = ref_md(md_op_o, md_signed_o, md_opa_o, md_opb_o);
    end else begin
      ex_valid_i  = (ph != PH_BUSY) && ($urandom_range(0, 3) == 0);
      result_ex_i = 32'($urandom);
    end
    #1;
    g = -1;
    if (ph == PH_IDLE && !flush_i) begin
      for (int k = 0; k < NumReq; k++) begin
        int idx;
        idx = (m_ptr + k) % NumReq;
        if (g < 0 && has_req[idx]) g = idx;
      end
    end
    exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    busy = (ph == PH_BUSY);
    check_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check_eq("mult_en", 64'(mult_en_o), 64'(busy && m_req.op < 2));
    check_eq("mult_sel", 64'(mult_sel_o), 64'(busy && m_req.op < 2));
    check_eq("div_en", 64'(div_en_o), 64'(busy && m_req.op >= 2));
    check_eq("div_sel", 64'(div_sel_o), 64'(busy && m_req.op >= 2));
    check_eq("ready_id", 64'(md_ready_id_o), 64'(busy));
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'(ph == PH_RESP));
    check_eq("imd_val_q", 64'(imd_val_q_o), 64'(m_imd));
    check_eq("last_lat", 64'(last_lat_o), 64'(m_last));
    if (ph == PH_RESP) begin
      check_eq("rsp_result", 64'(rsp_result_o), 64'(m_res));
      check_eq("rsp_id", 64'(rsp_id_o), 64'(m_id));
      check_eq("rsp_tag", 64'(rsp_tag_o), 64'(m_req.tag));
    end
    if (busy) begin
      check_eq("md_op", 64'(md_op_o), 64'(m_req.op));
      check_eq("md_signed", 64'(md_signed_o), 64'(m_req.sgn));
      check_eq("md_opa", 64'(md_opa_o), 64'(m_req.a));
      check_eq("md_opb", 64'(md_opb_o), 64'(m_req.b));
    end
    case (ph)
      PH_IDLE: begin
        if (g >= 0) begin
          m_req      = cur[g];
          m_id       = g;
          has_req[g] = 1'b0;
          m_ptr      = (g + 1) % NumReq;
          m_cnt      = 0;
          m_wait     = (wait_override >= 0) ? wait_override : int'($urandom_range(0, 4));
          wait_override = -1;
          ph         = PH_BUSY;
        end
      end
      PH_BUSY: begin
        if (imd_val_we_i) m_imd = imd_val_d_i;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (flush_i) begin
          ph = PH_DRAIN;
        end else if (ex_valid_i) begin
          m_last = m_cnt;
          m_res  = ref_md(m_req.op, m_req.sgn, m_req.a, m_req.b);
          ph     = PH_RESP;
        end else begin
          m_wait--;
        end
      end
      PH_RESP: begin
        if (flush_i) ph = PH_DRAIN;
        else if (rsp_ready_i) ph = PH_IDLE;
      end
      default: ph = PH_IDLE;
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    check_eq({tag, "_mult_en"}, 64'(mult_en_o), 64'd0);
    check_eq({tag, "_div_en"}, 64'(div_en_o), 64'd0);
    check_eq({tag, "_mult_sel"}, 64'(mult_sel_o), 64'd0);
    check_eq({tag, "_div_sel"}, 64'(div_sel_o), 64'd0);
    check_eq({tag, "_md_op"}, 64'(md_op_o), 64'd0);
    check_eq({tag, "_md_signed"}, 64'(md_signed_o), 64'd0);
    check_eq({tag, "_md_opa"}, 64'(md_opa_o), 64'd0);
    check_eq({tag, "_md_opb"}, 64'(md_opb_o), 64'd0);
    check_eq({tag, "_ready_id"}, 64'(md_ready_id_o), 64'd0);
    check_eq({tag, "_imd_val_q"}, 64'(imd_val_q_o), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check_eq({tag, "_rsp_result"}, 64'(rsp_result_o), 64'd0);
    check_eq({tag, "_rsp_id"}, 64'(rsp_id_o), 64'd0);
    check_eq({tag, "_rsp_tag"}, 64'(rsp_tag_o), 64'd0);
    check_eq({tag, "_last_lat"}, 64'(last_lat_o), 64'd0);
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    m_ptr = 0; m_id = 0; m_cnt = 0; m_wait = 0; m_last = 0;
    m_imd = '0; m_res = '0; m_req = '0;
    wait_override = -1;
  endtask

  task automatic quiet_inputs();
    req_valid_i = '0; flush_i = 1'b0; ex_valid_i = 1'b0; rsp_ready_i = 1'b0;
    imd_val_we_i = 1'b0; imd_val_d_i = '0; result_ex_i = '0;
  endtask

  initial begin
    int tries;
    rst_n = 1'b0;
    req_op_i = '0; req_signed_i = '0; req_opa_i = '0; req_opb_i = '0; req_tag_i = '0;
    quiet_inputs();
    model_reset();
    for (int i = 0; i < NumReq; i++) begin
      has_req[i] = 1'b0;
      cur[i] = '0;
    end
    dq0.push_back('{op: 2'd0, sgn: 2'b00, a: 32'd7, b: 32'd6, tag: 4'd3});
    dq1.push_back('{op: 2'd2, sgn: 2'b11, a: 32'hFFFF_FFF9, b: 32'd2, tag: 4'd5});
    dq1.push_back('{op: 2'd3, sgn: 2'b00, a: 32'h10, b: 32'd0, tag: 4'd6});
    repeat (3) @(posedge clk);
    #2;
    req_valid_i = 2'b11;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    req_valid_i = '0;
    rst_n = 1'b1;

    // Both requesters permanently valid: grants must alternate.
    allow_flush = 1'b0;
    req_pct = 100;
    repeat (60) step();

    allow_flush = 1'b1;
    req_pct = 40;
    repeat (3000) step();

    // One op held busy for longer than the latency counter range.
    allow_flush = 1'b0;
    wait_override = 300;
    repeat (400) step();

    // Reset in the middle of a division.
    dq1.push_back('{op: 2'd2, sgn: 2'b11, a: 32'd1000, b: 32'd7, tag: 4'd9});
    tries = 0;
    while (!(ph == PH_BUSY && m_req.op[1] && m_wait >= 3) && tries < 500) begin
      if (wait_override < 0) wait_override = 20;
      step();
      tries++;
    end
    check_eq("div_setup_timeout", 64'(tries < 500), 64'd1);
    repeat (2) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid_i = 2'b11;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b1;
    cur[0] = '{op: 2'd1, sgn: 2'b11, a: 32'h8000_0000, b: 32'd2, tag: 4'd12};
    has_req[0] = 1'b1;
    allow_flush = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
